// File: rtl/billiard_pkg.sv
// Shared billiard definitions: cue FSM state type, shot-speed constants and
// the direction indices used to address the per-key repeat generators.
package billiard_pkg;

  typedef enum logic [1:0] {IDLE, AIM, FIRE, SETTLE} cue_state_t;

  localparam int SPEED_STEP             = 200;
  localparam int MAX_SHOT_SPEED         = 1000;
  localparam int FIXED_POINT_MULTIPLIER = 64;
  // One charge step adds SPEED_STEP downstream, so this many steps reach full speed.
  localparam int MAX_STEPS              = MAX_SHOT_SPEED / SPEED_STEP;

  localparam int NUM_DIRS  = 4;
  localparam int DIR_UP    = 0;
  localparam int DIR_DOWN  = 1;
  localparam int DIR_LEFT  = 2;
  localparam int DIR_RIGHT = 3;

endpackage

// File: rtl/cue_shot_controller_if.sv
// Signal bundle between the keyboard/motion side and cue_shot_controller.
//  master: drives frame strobe, keys and ball position; observes shot outputs.
//  slave : the controller itself.
interface cue_shot_controller_if;
  logic               startOfFrame;
  logic               keyUp, keyDown, keyLeft, keyRight, keyShoot;
  logic signed [10:0] ballX, ballY;
  logic               chargeUp, chargeDown, chargeLeft, chargeRight;
  logic               releaseBall;
  logic signed [3:0]  chargeLevelX, chargeLevelY;
  logic               ballAtRest;
  logic               aimActive;

  modport master (
    output startOfFrame, keyUp, keyDown, keyLeft, keyRight, keyShoot, ballX, ballY,
    input  chargeUp, chargeDown, chargeLeft, chargeRight, releaseBall,
           chargeLevelX, chargeLevelY, ballAtRest, aimActive
  );

  modport slave (
    input  startOfFrame, keyUp, keyDown, keyLeft, keyRight, keyShoot, ballX, ballY,
    output chargeUp, chargeDown, chargeLeft, chargeRight, releaseBall,
           chargeLevelX, chargeLevelY, ballAtRest, aimActive
  );
endinterface

// File: rtl/cue_shot_controller_key_repeat_gen.sv
// key_repeat_gen: per-direction press/repeat timer.
//  Ports: clk, resetN (async low), startOfFrame, key (held level),
//         enable (controller in AIM), pulse_req (combinational, valid on SOF).
//  CUE_AUTOREPEAT_EN defined: held key requests again every REPEAT_FRAMES SOFs.
//  Undefined: one request per press; key must be seen low at an SOF to re-arm.
module key_repeat_gen #(
  parameter int REPEAT_FRAMES = 6
) (
  input  logic clk,
  input  logic resetN,
  input  logic startOfFrame,
  input  logic key,
  input  logic enable,
  output logic pulse_req
);

`ifdef CUE_AUTOREPEAT_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  localparam int CW = $clog2(REPEAT_FRAMES + 1);
  localparam logic [CW-1:0] LAST = CW'(REPEAT_FRAMES - 1);

  // cnt = number of held SOFs since the last request, 0 means "request now".
  // Without auto-repeat it parks at LAST until the key is released.
  logic [CW-1:0] cnt;

  assign pulse_req = enable && startOfFrame && key && (cnt == '0);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)              cnt <= '0;
    else if (!enable)         cnt <= '0;
    else if (startOfFrame) begin
      if (!key)               cnt <= '0;
      else if (cnt != LAST)   cnt <= cnt + 1'b1;
      else if (AUTO)          cnt <= '0;
    end
  end

endmodule

// File: rtl/cue_shot_controller.sv
// cue_shot_controller: shot-input front end for the white-ball motion block.
//  Ports: clk, resetN (async low), bus (cue_shot_controller_if.slave).
//  Turns held keys into rate-limited 1-clk charge pulses (AIM only), mirrors the
//  per-axis charge level, detects ball-at-rest from the read-back position, and
//  fires/confirms the shot. Repeat behaviour selected by CUE_AUTOREPEAT_EN.
module cue_shot_controller
  import billiard_pkg::*;
#(
  parameter int MAX_STEPS     = billiard_pkg::MAX_STEPS,
  parameter int REPEAT_FRAMES = 6,
  parameter int REST_FRAMES   = 8,
  parameter int SETTLE_FRAMES = 4
) (
  input logic                  clk,
  input logic                  resetN,
  cue_shot_controller_if.slave bus
);

  localparam int RCW = $clog2(REST_FRAMES + 1);
  localparam int SCW = $clog2(SETTLE_FRAMES + 1);
  localparam logic signed [3:0] LMAX = 4'(MAX_STEPS);
  localparam logic signed [3:0] LMIN = -LMAX;

  cue_state_t state, state_nxt;

  logic               shoot_d, shoot_edge, fire_go, chg_en;
  logic signed [3:0]  lvl_x, lvl_y;
  logic [NUM_DIRS-1:0] keys, req;
  logic               up_ok, down_ok, left_ok, right_ok;

  logic               seen, still, moved, rest;
  logic signed [10:0] prev_x, prev_y;
  logic [RCW-1:0]     rest_cnt, rest_cnt_nxt;
  logic [SCW-1:0]     settle_cnt;

  // ---- shoot edge / fire decision ----
  assign shoot_edge = bus.keyShoot && !shoot_d;
  assign fire_go    = (state == AIM) && shoot_edge && ((lvl_x != 0) || (lvl_y != 0));
  // Charging stops on the fire edge so a charge pulse never shares the FIRE clk.
  assign chg_en     = (state == AIM) && !fire_go;

  // ---- per-direction repeat generators ----
  assign keys = {bus.keyRight, bus.keyLeft, bus.keyDown, bus.keyUp};

  for (genvar d = 0; d < NUM_DIRS; d++) begin : g_key
    key_repeat_gen #(.REPEAT_FRAMES(REPEAT_FRAMES)) u_rep (
      .clk          (clk),
      .resetN       (resetN),
      .startOfFrame (bus.startOfFrame),
      .key          (keys[d]),
      .enable       (chg_en),
      .pulse_req    (req[d])
    );
  end

  // Opposite keys held together cancel the axis; saturation blocks the pulse.
  assign up_ok    = req[DIR_UP]    && !bus.keyDown  && (lvl_y < LMAX);
  assign down_ok  = req[DIR_DOWN]  && !bus.keyUp    && (lvl_y > LMIN);
  assign left_ok  = req[DIR_LEFT]  && !bus.keyRight && (lvl_x < LMAX);
  assign right_ok = req[DIR_RIGHT] && !bus.keyLeft  && (lvl_x > LMIN);

  // ---- rest detector ----
  // The first SOF after reset has no history; it counts as unchanged.
  assign still = !seen || ((bus.ballX == prev_x) && (bus.ballY == prev_y));
  assign moved = bus.startOfFrame && !still;

  always_comb begin
    rest_cnt_nxt = rest_cnt;
    if (!still)                               rest_cnt_nxt = '0;
    else if (rest_cnt != RCW'(REST_FRAMES))   rest_cnt_nxt = rest_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      seen     <= 1'b0;
      prev_x   <= '0;
      prev_y   <= '0;
      rest_cnt <= '0;
      rest     <= 1'b0;
    end else if (bus.startOfFrame) begin
      seen     <= 1'b1;
      prev_x   <= bus.ballX;
      prev_y   <= bus.ballY;
      rest_cnt <= rest_cnt_nxt;
      rest     <= (rest_cnt_nxt == RCW'(REST_FRAMES));
    end
  end

  // ---- levels, pulses, settle counter ----
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      shoot_d     <= 1'b0;
      lvl_x       <= '0;
      lvl_y       <= '0;
      bus.chargeUp    <= 1'b0;
      bus.chargeDown  <= 1'b0;
      bus.chargeLeft  <= 1'b0;
      bus.chargeRight <= 1'b0;
      settle_cnt  <= '0;
    end else begin
      shoot_d         <= bus.keyShoot;
      bus.chargeUp    <= up_ok;
      bus.chargeDown  <= down_ok;
      bus.chargeLeft  <= left_ok;
      bus.chargeRight <= right_ok;
      if (up_ok)         lvl_y <= lvl_y + 4'sd1;
      else if (down_ok)  lvl_y <= lvl_y - 4'sd1;
      if (left_ok)       lvl_x <= lvl_x + 4'sd1;
      else if (right_ok) lvl_x <= lvl_x - 4'sd1;
      // Ball moved after release: shot taken, charge consumed.
      if (state == SETTLE && moved) begin
        lvl_x <= '0;
        lvl_y <= '0;
      end
      if (state == FIRE)                              settle_cnt <= '0;
      else if (state == SETTLE && bus.startOfFrame)   settle_cnt <= settle_cnt + 1'b1;
    end
  end

  assign bus.chargeLevelX = lvl_x;
  assign bus.chargeLevelY = lvl_y;
  assign bus.ballAtRest   = rest;

  // ---- FSM ----
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (rest) state_nxt = AIM;
      AIM:    if (fire_go) state_nxt = FIRE;
      FIRE:   state_nxt = SETTLE;
      SETTLE: begin
        if (moved) state_nxt = IDLE;
        // No movement within the window: release refused, keep the charge.
        else if (bus.startOfFrame && settle_cnt == SCW'(SETTLE_FRAMES - 1)) state_nxt = AIM;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.releaseBall = (state == FIRE);
    bus.aimActive   = (state == AIM);
  end

endmodule

// File: tb/tb_cue_shot_controller.sv
// Bench for cue_shot_controller: directed scenarios with literal expectations
// followed by randomized frames, all outputs checked every clk against a
// frame-level reference model.
module tb_cue_shot_controller;

  localparam int MAXS = 5, REP = 6, REST = 8, SETL = 4, FPER = 4;
`ifdef CUE_AUTOREPEAT_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic clk = 1'b0;
  logic resetN = 1'b0;
  cue_shot_controller_if bus();

  cue_shot_controller dut (.clk(clk), .resetN(resetN), .bus(bus));

  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0, cyc = 0;
  int cnt_up = 0, cnt_dn = 0, cnt_lf = 0, cnt_rt = 0, cnt_rel = 0;

  // ---------------- reference model ----------------
  // Phases: 0 idle, 1 aim, 2 fire, 3 settle.
  int m_phase, m_lx, m_ly, m_still, m_settle_sofs, m_px, m_py, nxt;
  int held[4];
  bit m_have_prev, m_shoot_prev, m_rest;
  bit e_up, e_dn, e_lf, e_rt;
  bit sof, edge_s, moved, fire, en;
  bit want[4];
  bit k[4];

  always @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      m_phase = 0; m_lx = 0; m_ly = 0; m_still = 0; m_settle_sofs = 0;
      m_px = 0; m_py = 0; m_have_prev = 0; m_shoot_prev = 0; m_rest = 0;
      e_up = 0; e_dn = 0; e_lf = 0; e_rt = 0;
      for (int d = 0; d < 4; d++) held[d] = 0;
    end else begin
      sof    = bus.startOfFrame;
      k[0] = bus.keyUp; k[1] = bus.keyDown; k[2] = bus.keyLeft; k[3] = bus.keyRight;
      edge_s = bus.keyShoot && !m_shoot_prev;
      m_shoot_prev = bus.keyShoot;
      moved  = sof && m_have_prev && (int'(bus.ballX) != m_px || int'(bus.ballY) != m_py);
      fire   = (m_phase == 1) && edge_s && (m_lx != 0 || m_ly != 0);
      en     = (m_phase == 1) && !fire;
      // held[d]: SOFs the key has been seen held while aiming
      for (int d = 0; d < 4; d++) begin
        want[d] = 0;
        if (!en) held[d] = 0;
        else if (sof) begin
          if (!k[d]) held[d] = 0;
          else begin
            want[d] = AUTO ? (held[d] % REP == 0) : (held[d] == 0);
            held[d]++;
          end
        end
      end
      e_up = want[0] && !k[1] && m_ly <  MAXS;
      e_dn = want[1] && !k[0] && m_ly > -MAXS;
      e_lf = want[2] && !k[3] && m_lx <  MAXS;
      e_rt = want[3] && !k[2] && m_lx > -MAXS;
      m_ly = m_ly + int'(e_up) - int'(e_dn);
      m_lx = m_lx + int'(e_lf) - int'(e_rt);
      nxt = m_phase;
      case (m_phase)
        0: if (m_rest) nxt = 1;
        1: if (fire) nxt = 2;
        2: begin nxt = 3; m_settle_sofs = 0; end
        default: begin
          if (moved) begin m_lx = 0; m_ly = 0; nxt = 0; end
          else if (sof) begin
            m_settle_sofs++;
            if (m_settle_sofs == SETL) nxt = 1;
          end
        end
      endcase
      m_phase = nxt;
      if (sof) begin
        if (moved) m_still = 0;
        else if (m_still < REST) m_still++;
        m_px = bus.ballX; m_py = bus.ballY; m_have_prev = 1;
        m_rest = (m_still == REST);
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [14:0] got_v, exp_v;
  always @(posedge clk) begin
    #2;
    cyc++;
    got_v = {bus.chargeUp, bus.chargeDown, bus.chargeLeft, bus.chargeRight, bus.releaseBall,
             bus.chargeLevelX, bus.chargeLevelY, bus.ballAtRest, bus.aimActive};
    exp_v = {e_up, e_dn, e_lf, e_rt, (m_phase == 2),
             4'(m_lx), 4'(m_ly), m_rest, (m_phase == 1)};
    vectors++;
    if (got_v !== exp_v) begin
      miscompares++;
      $display("FAIL outputs cycle %0d got %h expected %h (up,dn,lf,rt,rel,lx,ly,rest,aim)",
               cyc, got_v, exp_v);
    end
    cnt_up += int'(bus.chargeUp);   cnt_dn += int'(bus.chargeDown);
    cnt_lf += int'(bus.chargeLeft); cnt_rt += int'(bus.chargeRight);
    cnt_rel += int'(bus.releaseBall);
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      @(negedge clk); bus.startOfFrame = 1'b1;
      @(negedge clk); bus.startOfFrame = 1'b0;
      repeat (FPER - 2) @(negedge clk);
    end
  endtask

  task automatic clr_counts();
    cnt_up = 0; cnt_dn = 0; cnt_lf = 0; cnt_rt = 0; cnt_rel = 0;
  endtask

  task automatic shoot();
    bus.keyShoot = 1'b1; tick(2); bus.keyShoot = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.startOfFrame = 0; bus.keyUp = 0; bus.keyDown = 0; bus.keyLeft = 0;
    bus.keyRight = 0; bus.keyShoot = 0; bus.ballX = 11'sd100; bus.ballY = 11'sd50;
    tick(3);
    check("reset_levelX", int'(bus.chargeLevelX), 0);
    check("reset_aim", int'(bus.aimActive), 0);
    check("reset_release", int'(bus.releaseBall), 0);
    resetN = 1'b1;

    // rest detection: 7 static SOFs not enough, 8th declares rest and enters AIM
    frames(7);
    check("rest_after7", int'(bus.ballAtRest), 0);
    check("aim_after7", int'(bus.aimActive), 0);
    frames(1);
    check("rest_after8", int'(bus.ballAtRest), 1);
    check("aim_after8", int'(bus.aimActive), 1);

    // shoot with both levels zero is ignored
    clr_counts(); shoot(); tick(2);
    check("zero_shoot_release", cnt_rel, 0);
    check("zero_shoot_aim", int'(bus.aimActive), 1);

    // keyUp held 40 frames
    clr_counts(); bus.keyUp = 1; frames(40); bus.keyUp = 0; frames(1);
    check("up_pulses", cnt_up, AUTO ? 5 : 1);
    check("up_levelY", int'(bus.chargeLevelY), AUTO ? 5 : 1);

    // keyLeft held 20 frames, released, pressed again
    clr_counts(); bus.keyLeft = 1; frames(20); bus.keyLeft = 0; frames(1);
    check("left_levelX_1", int'(bus.chargeLevelX), AUTO ? 4 : 1);
    bus.keyLeft = 1; frames(5); bus.keyLeft = 0; frames(1);
    check("left_levelX_2", int'(bus.chargeLevelX), AUTO ? 5 : 2);
    check("left_pulses", cnt_lf, AUTO ? 5 : 2);

    // opposite keys cancel the axis
    clr_counts(); bus.keyUp = 1; bus.keyDown = 1; frames(8); bus.keyUp = 0; bus.keyDown = 0;
    frames(1);
    check("updown_pulses", cnt_up + cnt_dn, 0);

    // shot accepted: ball moves at next SOF
    clr_counts(); shoot(); bus.ballX = 11'sd103; frames(2);
    check("shot_release", cnt_rel, 1);
    check("shot_levelX", int'(bus.chargeLevelX), 0);
    check("shot_levelY", int'(bus.chargeLevelY), 0);
    check("shot_aim", int'(bus.aimActive), 0);

    // back to rest, charge levelY to -3
    frames(9);
    check("rest_again_aim", int'(bus.aimActive), 1);
    repeat (3) begin bus.keyDown = 1; frames(1); bus.keyDown = 0; frames(1); end
    check("down_levelY", int'(bus.chargeLevelY), -3);

    // shot refused: ball static through the settle window
    shoot(); frames(2);
    check("settle_aim_mid", int'(bus.aimActive), 0);
    frames(3);
    check("refused_aim", int'(bus.aimActive), 1);
    check("refused_levelY", int'(bus.chargeLevelY), -3);

    // reset while settling
    shoot(); tick(1);
    resetN = 1'b0; #1;
    check("midreset_levelY", int'(bus.chargeLevelY), 0);
    check("midreset_rest", int'(bus.ballAtRest), 0);
    check("midreset_aim", int'(bus.aimActive), 0);
    check("midreset_release", int'(bus.releaseBall), 0);
    tick(2); resetN = 1'b1;

    // randomized frames, checked by the model
    for (int f = 0; f < 400; f++) begin
      bus.keyUp    = ($urandom_range(0, 9) < 3);
      bus.keyDown  = ($urandom_range(0, 9) < 2);
      bus.keyLeft  = ($urandom_range(0, 9) < 3);
      bus.keyRight = ($urandom_range(0, 9) < 2);
      bus.keyShoot = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 19) == 0) bus.ballX = bus.ballX + 11'sd1;
      if ($urandom_range(0, 39) == 0) bus.ballY = bus.ballY - 11'sd2;
      frames(1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
